// File: rtl/control_unit_pkg.sv
// Shared types for the control unit: ALU operation codes, FSM states, opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_unit_pkg;

  // Encoding order matches opcodes 0x0-0xB, so an ALU opcode casts directly to alu_op_e.
  typedef enum logic [3:0] {
    ALU_NOP = 4'h0,
    ALU_THR = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h3,
    ALU_SHL = 4'h4,
    ALU_ROL = 4'h5,
    ALU_SHR = 4'h6,
    ALU_ROR = 4'h7,
    ALU_AND = 4'h8,
    ALU_OR  = 4'h9,
    ALU_XOR = 4'hA,
    ALU_NOT = 4'hB
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_FETCH_TGT,
    ST_HALT
  } cu_state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_THR = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_ROL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ROR = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_NOT = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Opcode classifier: maps a 4-bit opcode to an ALU op and an instruction class.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode in; alu_op (NOP for non-ALU opcodes), is_alu, is_jump, is_halt out.
module instr_decoder
  import control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_op_e    alu_op,
  output logic       is_alu,
  output logic       is_jump,
  output logic       is_halt
);

  always_comb begin
    alu_op  = ALU_NOP;
    is_alu  = 1'b0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    if (opcode <= OP_NOT) begin
      is_alu = 1'b1;
      alu_op = alu_op_e'(opcode);
    end else if (opcode == OP_HLT) begin
      is_halt = 1'b1;
    end else begin
      // JMP, JZ, JC: the only remaining opcodes
      is_jump = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/decode/execute sequencer for a byte-wide accumulator-style core.
// Latency: ALU op 3 cycles, jump FETCH+DECODE+FETCH_TGT, with zero-wait memory; each memory wait adds a cycle.
// Backpressure: mem_req and mem_addr are held until mem_ack; mem_ack without mem_req is ignored.
// Ports: clk/rst_n (sync, active-low); mem_req/mem_addr/mem_ack/mem_data fetch port;
//        alu_op/alu_is_zero/alu_is_carry ALU control; reg_sel_a/reg_sel_b/reg_we register file;
//        flag_z/flag_c latched flags; pc program counter; halted in HALT.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      mem_req,
  output logic [DATA_BUS_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic [DATA_BUS_WIDTH-1:0] mem_data,
  output alu_op_e                   alu_op,
  input  logic                      alu_is_zero,
  input  logic                      alu_is_carry,
  output logic [1:0]                reg_sel_a,
  output logic [1:0]                reg_sel_b,
  output logic                      reg_we,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic [DATA_BUS_WIDTH-1:0] pc,
  output logic                      halted
);

  localparam logic [DATA_BUS_WIDTH-1:0] PC_ONE = {{(DATA_BUS_WIDTH-1){1'b0}}, 1'b1};

  cu_state_e                 state, state_nxt;
  logic [DATA_BUS_WIDTH-1:0] ir;
  logic [3:0]                opcode;
  alu_op_e                   dec_alu_op;
  logic                      dec_is_alu;
  logic                      dec_is_jump;
  logic                      dec_is_halt;
  logic                      jump_taken;

  assign opcode = ir[7:4];

  instr_decoder u_instr_decoder (
    .opcode  (opcode),
    .alu_op  (dec_alu_op),
    .is_alu  (dec_is_alu),
    .is_jump (dec_is_jump),
    .is_halt (dec_is_halt)
  );

  // Conditional jumps test the flags as left by the last non-NOP ALU op.
  assign jump_taken = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && flag_z) ||
                      ((opcode == OP_JC) && flag_c);

  assign mem_addr  = pc;
  assign reg_sel_a = ir[3:2];
  assign reg_sel_b = ir[1:0];
  assign halted    = (state == ST_HALT);

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    alu_op    = ALU_NOP;
    reg_we    = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_is_alu)       state_nxt = ST_EXECUTE;
        else if (dec_is_jump) state_nxt = ST_FETCH_TGT;
        else if (dec_is_halt) state_nxt = ST_HALT;
      end
      ST_EXECUTE: begin
        alu_op    = dec_alu_op;
        reg_we    = (dec_alu_op != ALU_NOP);
        state_nxt = ST_FETCH;
      end
      ST_FETCH_TGT: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Dominates any same-cycle mem_ack, abandoning an in-flight fetch.
      state  <= ST_FETCH;
      pc     <= '0;
      ir     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_FETCH: begin
          if (mem_ack) begin
            ir <= mem_data;
            pc <= pc + PC_ONE;
          end
        end
        ST_EXECUTE: begin
          if (dec_alu_op != ALU_NOP) begin
            flag_z <= alu_is_zero;
            flag_c <= alu_is_carry;
          end
        end
        ST_FETCH_TGT: begin
          if (mem_ack) pc <= jump_taken ? mem_data : pc + PC_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule
